// File: rtl/presc_updown_counter.sv
//------------------------------------------------------------------------------
// presc_updown_counter
//   Up/down counter with a programmable clock-enable prescaler, load, clear,
//   wrap/saturate bounds, terminal-count pulse and sticky overflow flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module presc_updown_counter #(
   parameter int              WIDTH     = 7,
   parameter int              DIV_W     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] div_val,
   input  logic             clr,
   input  logic             write_en,
   input  logic [WIDTH-1:0] datain,
   input  logic             inc,
   input  logic             dec,
   input  logic             mode_sat,
   output logic [WIDTH-1:0] dout,
   output logic             tick,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] c_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] c_PONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] r_presc;
   logic [WIDTH-1:0] r_dout;
   logic             r_tc;
   logic             r_ovf;

   logic             w_tick;
   logic             w_step;
   logic             w_up;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_boundary;
   logic [WIDTH-1:0] w_next;

   // Using >= (not ==) lets a lowered divisor fire at once instead of
   // waiting for the prescaler to wrap through its full range.
   assign w_tick = (r_presc >= div_val);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
      end else if (clr) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + c_PONE;
      end
   end

   assign w_step    = w_tick & (inc ^ dec);
   assign w_up      = inc;
   assign w_at_max  = (r_dout == c_MAX);
   assign w_at_zero = (r_dout == c_ZERO);

   // Boundary is flagged in both modes; only the resulting value differs.
   assign w_boundary = w_step & (w_up ? w_at_max : w_at_zero);

   always_comb begin
      w_next = r_dout;
      if (w_up) begin
         if (!w_at_max) begin
            w_next = r_dout + c_ONE;
         end else begin
            w_next = mode_sat ? c_MAX : c_ZERO;
         end
      end else begin
         if (!w_at_zero) begin
            w_next = r_dout - c_ONE;
         end else begin
            w_next = mode_sat ? c_ZERO : c_MAX;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout <= RESET_VAL;
         r_tc   <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (clr) begin
         r_dout <= c_ZERO;
         r_tc   <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (write_en) begin
         r_dout <= datain;
         r_tc   <= 1'b0;
      end else if (w_step) begin
         r_dout <= w_next;
         r_tc   <= w_boundary;
         r_ovf  <= r_ovf | w_boundary;
      end else begin
         r_tc   <= 1'b0;
      end
   end

   assign dout = r_dout;
   assign tick = w_tick;
   assign tc   = r_tc;
   assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_presc_updown_counter.sv
//------------------------------------------------------------------------------
// tb_presc_updown_counter
//   Table-driven and directed self-checking bench for presc_updown_counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_presc_updown_counter;

   localparam int WIDTH = 7;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [DIV_W-1:0] div_val;
   logic             clr;
   logic             write_en;
   logic [WIDTH-1:0] datain;
   logic             inc;
   logic             dec;
   logic             mode_sat;
   logic [WIDTH-1:0] dout;
   logic             tick;
   logic             tc;
   logic             ovf;

   int n_cmp = 0;
   int n_bad = 0;

   presc_updown_counter #(
      .WIDTH     (WIDTH),
      .DIV_W     (DIV_W),
      .RESET_VAL ('0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .div_val  (div_val),
      .clr      (clr),
      .write_en (write_en),
      .datain   (datain),
      .inc      (inc),
      .dec      (dec),
      .mode_sat (mode_sat),
      .dout     (dout),
      .tick     (tick),
      .tc       (tc),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             clr;
      logic             we;
      logic [WIDTH-1:0] din;
      logic             inc;
      logic             dec;
      logic             sat;
      logic [WIDTH-1:0] e_dout;
      logic             e_tc;
      logic             e_ovf;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(input logic c, input logic w, input int d,
                               input logic i, input logic dn, input logic s,
                               input int ed, input logic et, input logic eo);
      vec_t v;
      v.clr = c; v.we = w; v.din = WIDTH'(d); v.inc = i; v.dec = dn; v.sat = s;
      v.e_dout = WIDTH'(ed); v.e_tc = et; v.e_ovf = eo;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance one edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr = 0; write_en = 0; datain = '0; inc = 0; dec = 0; mode_sat = 0;
   endtask

   task automatic check_state(input string tag, input int ed, input int et, input int eo);
      check({tag, ".dout"}, int'(dout), ed);
      check({tag, ".tc"},   int'(tc),   et);
      check({tag, ".ovf"},  int'(ovf),  eo);
   endtask

   initial begin
      // clr we din inc dec sat -> dout tc ovf  (div_val=0: tick every cycle)
      vecs[0]  = mk(0,1,126,0,0,0, 126,0,0);
      vecs[1]  = mk(0,0,0,  1,0,0, 127,0,0);
      vecs[2]  = mk(0,0,0,  1,0,0,   0,1,1);
      vecs[3]  = mk(0,0,0,  1,0,0,   1,0,1);
      vecs[4]  = mk(0,0,0,  1,1,0,   1,0,1);
      vecs[5]  = mk(0,0,0,  0,0,0,   1,0,1);
      vecs[6]  = mk(0,1,127,0,0,1, 127,0,1);
      vecs[7]  = mk(0,0,0,  1,0,1, 127,1,1);
      vecs[8]  = mk(0,0,0,  1,0,1, 127,1,1);
      vecs[9]  = mk(0,0,0,  0,1,1, 126,0,1);
      vecs[10] = mk(1,0,0,  0,0,0,   0,0,0);
      vecs[11] = mk(0,0,0,  0,1,1,   0,1,1);
      vecs[12] = mk(0,0,0,  0,1,0, 127,1,1);
      vecs[13] = mk(0,0,0,  1,1,0, 127,0,1);
      vecs[14] = mk(1,1,5,  1,0,0,   0,0,0);
      vecs[15] = mk(0,1,5,  1,0,0,   5,0,0);
      vecs[16] = mk(0,0,0,  0,1,0,   4,0,0);

      reset = 1; div_val = '0; idle_inputs();
      #2;
      step(); step();
      check_state("reset", 0, 0, 0);
      reset = 0;

      // Prescaler divide-by-4: tick only while presc==3.
      div_val = 16'd3; inc = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         check($sformatf("div4.tick[%0d]", i), int'(tick), (i % 4 == 3) ? 1 : 0);
         step();
         check($sformatf("div4.dout[%0d]", i), int'(dout), (i + 1) / 4);
      end
      check("div4.tc", int'(tc), 0);

      div_val = '0;
      for (int i = 0; i < 17; i++) begin
         clr = vecs[i].clr; write_en = vecs[i].we; datain = vecs[i].din;
         inc = vecs[i].inc; dec = vecs[i].dec; mode_sat = vecs[i].sat;
         step();
         check_state($sformatf("vec%0d", i), int'(vecs[i].e_dout),
                     int'(vecs[i].e_tc), int'(vecs[i].e_ovf));
      end

      // Lowering the divisor below the running prescaler fires at once.
      idle_inputs(); clr = 1; step(); clr = 0;
      div_val = 16'd10; inc = 1;
      for (int i = 0; i < 7; i++) step();
      #1;
      check("div10.no_tick", int'(tick), 0);
      check("div10.dout", int'(dout), 0);
      div_val = 16'd2;
      #1;
      check("lower.tick_now", int'(tick), 1);
      step();
      check("lower.dout", int'(dout), 1);
      check("lower.presc0_tick", int'(tick), 0);
      step(); step();
      check("lower.tick_again", int'(tick), 1);

      // Mid-count reset after overflow has been set.
      div_val = '0; write_en = 1; datain = 7'd127; inc = 0; step();
      write_en = 0; inc = 1; step();
      check_state("pre_reset", 0, 1, 1);
      reset = 1; step(); step();
      check_state("mid_reset", 0, 0, 0);
      reset = 0; inc = 0; div_val = 16'd5;
      #1;
      check("mid_reset.presc", int'(tick), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
